// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel timing generator. Sits directly after the pixel-clock strobe
// divider. The horizontal and vertical counters advance once per pixel
// strobe. All decode outputs are registered from the *next* counter values,
// so hsync/vsync/de and the start pulses stay aligned with x_o/y_o.
//
// Ports
//   clk_i          system clock
//   arst_i         asynchronous reset, active high
//   pix_strb_i     one-clk pixel-advance strobe
//   hsync_o        horizontal sync, registered, polarity HSYNC_POL
//   vsync_o        vertical sync, registered, polarity VSYNC_POL
//   de_o           high while the current pixel is visible
//   x_o            horizontal count (0 .. H_TOTAL-1)
//   y_o            vertical count   (0 .. V_TOTAL-1)
//   line_start_o   one-clk pulse when x_o becomes 0
//   frame_start_o  one-clk pulse when (x_o,y_o) becomes (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          pix_strb_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // Every timing segment must be at least one pixel/line long.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_gen: all timing parameters must be >= 1");
  end

  // Boundary constants at counter width. Each is strictly below the
  // corresponding total because every porch is at least 1, so they fit.
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_DE_END   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_DE_END   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;

  logic [XW-1:0] h_next;
  logic [YW-1:0] v_next;
  logic          h_wrap;
  logic          de_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          line_next;
  logic          frame_next;

  // Next-position arithmetic. Only used on a strobe edge; between strobes
  // the registers simply hold.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_next = h_wrap ? '0 : h_cnt + XW'(1);

    v_next = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
    end
  end

  // Decode from the next position so the registered outputs describe the
  // same pixel that x_o/y_o will show after the edge. vsync is a pure
  // function of v_next, so it can only move when h_next returns to 0.
  always_comb begin
    de_next    = (h_next < H_DE_END) && (v_next < V_DE_END);
    hsync_next = ((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END)) ?
                 HSYNC_POL : ~HSYNC_POL;
    vsync_next = ((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END)) ?
                 VSYNC_POL : ~VSYNC_POL;
    line_next  = (h_next == '0);
    frame_next = (h_next == '0) && (v_next == '0);
  end

  // Reset parks the counters on the last pixel of the frame so that the
  // first strobe after release lands on (0,0) and fires frame_start_o.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      de_o          <= 1'b0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      // Pulses last exactly one clk, even with back-to-back strobes.
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (pix_strb_i) begin
        h_cnt         <= h_next;
        v_cnt         <= v_next;
        de_o          <= de_next;
        hsync_o       <= hsync_next;
        vsync_o       <= vsync_next;
        line_start_o  <= line_next;
        frame_start_o <= frame_next;
      end
    end
  end

  assign x_o = h_cnt;
  assign y_o = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Default 640x480 timing.
  localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
  localparam int VA = 480, VFP = 10, VSW = 2, VBP = 33;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  // Tiny timing with active-high syncs so whole frames fit in the budget.
  localparam int SHA = 8, SHFP = 2, SHSW = 3, SHBP = 2;
  localparam int SVA = 6, SVFP = 2, SVSW = 2, SVBP = 3;
  localparam int SHT = SHA + SHFP + SHSW + SHBP;
  localparam int SVT = SVA + SVFP + SVSW + SVBP;

  logic clk_i = 1'b0;
  logic arst_i = 1'b1;
  logic pix_strb_i = 1'b0;

  logic       hsync_d, vsync_d, de_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       hsync_s, vsync_s, de_s, ls_s, fs_s;
  logic [3:0] x_s, y_s;

  int checks = 0;
  int errors = 0;

  // Reference model: linear pixel index within the frame plus pulse flags.
  int n_d, n_s;
  bit mls_d, mfs_d, mls_s, mfs_s;

  always #5 clk_i = ~clk_i;

  vga_timing_gen u_dut_d (
    .clk_i(clk_i), .arst_i(arst_i), .pix_strb_i(pix_strb_i),
    .hsync_o(hsync_d), .vsync_o(vsync_d), .de_o(de_d),
    .x_o(x_d), .y_o(y_d),
    .line_start_o(ls_d), .frame_start_o(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHSW), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVSW), .V_BP(SVBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_s (
    .clk_i(clk_i), .arst_i(arst_i), .pix_strb_i(pix_strb_i),
    .hsync_o(hsync_s), .vsync_o(vsync_s), .de_o(de_s),
    .x_o(x_s), .y_o(y_s),
    .line_start_o(ls_s), .frame_start_o(fs_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for linear index n under a given timing.
  function automatic void exp_of(input int n,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw,
                                 input bit hpol, input bit vpol,
                                 output int x, output int y,
                                 output bit de, output bit hsy, output bit vsy);
    int ht;
    ht  = ha + hfp + hsw + hbp;
    x   = n % ht;
    y   = n / ht;
    de  = (x < ha) && (y < va);
    hsy = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : !hpol;
    vsy = (y >= va + vfp && y < va + vfp + vsw) ? vpol : !vpol;
  endfunction

  task automatic model_reset();
    n_d = HT * VT - 1;
    n_s = SHT * SVT - 1;
    mls_d = 0; mfs_d = 0; mls_s = 0; mfs_s = 0;
  endtask

  task automatic model_edge();
    if (arst_i) begin
      model_reset();
    end else begin
      mls_d = 0; mfs_d = 0; mls_s = 0; mfs_s = 0;
      if (pix_strb_i) begin
        n_d = (n_d + 1) % (HT * VT);
        n_s = (n_s + 1) % (SHT * SVT);
        mls_d = (n_d % HT) == 0;
        mfs_d = (n_d == 0);
        mls_s = (n_s % SHT) == 0;
        mfs_s = (n_s == 0);
      end
    end
  endtask

  task automatic check_all();
    int x, y;
    bit de, hsy, vsy;
    exp_of(n_d, HA, HFP, HSW, HBP, VA, VFP, VSW, 1'b0, 1'b0, x, y, de, hsy, vsy);
    chk("d_x", int'(x_d), x);
    chk("d_y", int'(y_d), y);
    chk("d_de", int'(de_d), int'(de));
    chk("d_hsync", int'(hsync_d), int'(hsy));
    chk("d_vsync", int'(vsync_d), int'(vsy));
    chk("d_line_start", int'(ls_d), int'(mls_d));
    chk("d_frame_start", int'(fs_d), int'(mfs_d));
    exp_of(n_s, SHA, SHFP, SHSW, SHBP, SVA, SVFP, SVSW, 1'b1, 1'b1, x, y, de, hsy, vsy);
    chk("s_x", int'(x_s), x);
    chk("s_y", int'(y_s), y);
    chk("s_de", int'(de_s), int'(de));
    chk("s_hsync", int'(hsync_s), int'(hsy));
    chk("s_vsync", int'(vsync_s), int'(vsy));
    chk("s_line_start", int'(ls_s), int'(mls_s));
    chk("s_frame_start", int'(fs_s), int'(mfs_s));
  endtask

  // Drive strobe, take one clock edge, compare 1 time unit later.
  task automatic step(input bit strb);
    pix_strb_i = strb;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset between edges and check that it takes effect without a clock.
  task automatic async_reset();
    arst_i = 1'b1;
    model_reset();
    #1;
    check_all();
  endtask

  typedef struct {
    bit strb;
    int x, y;
    bit de, hs, vs, ls, fs;
  } vec_t;

  vec_t vt[9];

  initial begin : main
    int lo_cnt, lo_first, lo_last, de639, de640, hs752;
    int ls_cnt, fs_cnt, vs_lines, vs_first, vs_bad;
    bit found, prev_vs;

    // strobe every 4 clks after reset release
    vt[0] = '{1, 0, 0, 1, 1, 1, 1, 1};
    vt[1] = '{0, 0, 0, 1, 1, 1, 0, 0};
    vt[2] = '{0, 0, 0, 1, 1, 1, 0, 0};
    vt[3] = '{0, 0, 0, 1, 1, 1, 0, 0};
    vt[4] = '{1, 1, 0, 1, 1, 1, 0, 0};
    vt[5] = '{0, 1, 0, 1, 1, 1, 0, 0};
    vt[6] = '{0, 1, 0, 1, 1, 1, 0, 0};
    vt[7] = '{0, 1, 0, 1, 1, 1, 0, 0};
    vt[8] = '{1, 2, 0, 1, 1, 1, 0, 0};

    // Reset held with strobes active: no advance.
    model_reset();
    arst_i = 1'b1;
    pix_strb_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_all();
    chk("rst_x", int'(x_d), 799);
    chk("rst_y", int'(y_d), 524);
    chk("rst_de", int'(de_d), 0);
    chk("rst_hsync", int'(hsync_d), 1);
    chk("rst_vsync", int'(vsync_d), 1);
    chk("rst_pulses", int'(ls_d) + int'(fs_d), 0);
    pix_strb_i = 1'b0;
    arst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(vt[i].strb);
      chk($sformatf("tbl%0d_x", i), int'(x_d), vt[i].x);
      chk($sformatf("tbl%0d_y", i), int'(y_d), vt[i].y);
      chk($sformatf("tbl%0d_de", i), int'(de_d), int'(vt[i].de));
      chk($sformatf("tbl%0d_hs", i), int'(hsync_d), int'(vt[i].hs));
      chk($sformatf("tbl%0d_vs", i), int'(vsync_d), int'(vt[i].vs));
      chk($sformatf("tbl%0d_ls", i), int'(ls_d), int'(vt[i].ls));
      chk($sformatf("tbl%0d_fs", i), int'(fs_d), int'(vt[i].fs));
    end

    // Line wrap 799 -> 0 with y 0 -> 1.
    found = 0;
    for (int k = 0; k < 2 * HT && !found; k++) begin
      step(1'b1);
      if (x_d == 10'd0) found = 1;
    end
    chk("reach_line1", int'(found), 1);
    chk("wrap_y", int'(y_d), 1);
    chk("wrap_ls", int'(ls_d), 1);
    chk("wrap_fs", int'(fs_d), 0);

    // One full line with a strobe every clk.
    lo_cnt = 0; lo_first = -1; lo_last = -1; de639 = -1; de640 = -1; hs752 = -1;
    for (int k = 0; k < HT; k++) begin
      if (!hsync_d) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = int'(x_d);
        lo_last = int'(x_d);
      end
      if (x_d == 10'd639) de639 = int'(de_d);
      if (x_d == 10'd640) de640 = int'(de_d);
      if (x_d == 10'd752) hs752 = int'(hsync_d);
      step(1'b1);
    end
    chk("hsync_low_count", lo_cnt, HSW);
    chk("hsync_first_low", lo_first, 656);
    chk("hsync_last_low", lo_last, 751);
    chk("hsync_at_752", hs752, 1);
    chk("de_at_639", de639, 1);
    chk("de_at_640", de640, 0);
    chk("line2_y", int'(y_d), 2);

    // Small-timing instance: a whole frame from frame_start to frame_start.
    found = 0;
    for (int k = 0; k < SHT * SVT + 4 && !found; k++) begin
      step(1'b1);
      if (fs_s) found = 1;
    end
    chk("reach_s_frame", int'(found), 1);
    ls_cnt = 0; fs_cnt = 0; vs_lines = 0; vs_first = -1; vs_bad = 0;
    prev_vs = vsync_s;
    for (int k = 0; k < SHT * SVT; k++) begin
      if (ls_s) ls_cnt++;
      if (fs_s) fs_cnt++;
      if (vsync_s && x_s == 4'd0) begin
        vs_lines++;
        if (vs_first < 0) vs_first = int'(y_s);
      end
      if (vsync_s != prev_vs && x_s != 4'd0) vs_bad++;
      prev_vs = vsync_s;
      step(1'b1);
    end
    chk("s_line_starts_per_frame", ls_cnt, SVT);
    chk("s_frame_starts_per_frame", fs_cnt, 1);
    chk("s_vsync_lines", vs_lines, SVSW);
    chk("s_vsync_first_line", vs_first, SVA + SVFP);
    chk("s_vsync_off_boundary", vs_bad, 0);
    chk("s_frame_again", int'(fs_s), 1);

    // Random strobe pattern with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        step(1'b1);
        arst_i = 1'b0;
      end
      case ($urandom_range(0, 3))
        0:       step(1'b1);
        1:       step(1'b0);
        default: step($urandom_range(0, 3) == 0);
      endcase
    end

    // Reset mid-line at x=300 with strobes active.
    found = 0;
    for (int k = 0; k < 2 * HT && !found; k++) begin
      step(1'b1);
      if (x_d == 10'd300) found = 1;
    end
    chk("reach_x300", int'(found), 1);
    pix_strb_i = 1'b1;
    async_reset();
    chk("mid_rst_x", int'(x_d), 799);
    chk("mid_rst_y", int'(y_d), 524);
    chk("mid_rst_de", int'(de_d), 0);
    chk("mid_rst_hsync", int'(hsync_d), 1);
    chk("mid_rst_vsync", int'(vsync_d), 1);
    step(1'b1);
    chk("strobe_in_rst_x", int'(x_d), 799);
    arst_i = 1'b0;
    step(1'b1);
    chk("post_rst_x", int'(x_d), 0);
    chk("post_rst_y", int'(y_d), 0);
    chk("post_rst_de", int'(de_d), 1);
    chk("post_rst_fs", int'(fs_d), 1);
    chk("post_rst_ls", int'(ls_d), 1);
    step(1'b0);
    chk("post_rst_fs_clear", int'(fs_d), 0);
    chk("post_rst_x_hold", int'(x_d), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel timing generator directly downstream of the pixel-clock strobe divider.
- Advances horizontal and vertical counters once per pixel strobe.
- Produces hsync, vsync, data-enable, the pixel coordinates, and single-cycle line/frame start pulses for the character renderer and the VGA pads.
- Runs in the system clock domain. The pixel rate is set only by the strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync_o (0 = active-low)

Ports:
- clk_i  input  1  system clock
- arst_i  input  1  reset, asynchronous, active-high
- pix_strb_i  input  1  one-clk pixel-advance strobe from the divider
- hsync_o  output  1  horizontal sync, registered
- vsync_o  output  1  vertical sync, registered
- de_o  output  1  high while the current pixel is visible
- x_o  output  XW  horizontal count; XW = $clog2(H_TOTAL)
- y_o  output  YW  vertical count; YW = $clog2(V_TOTAL)
- line_start_o  output  1  one-clk pulse when x_o becomes 0
- frame_start_o  output  1  one-clk pulse when (x_o,y_o) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). All parameters must be ≥1; elaboration fails otherwise.
- Reset (arst_i high, async): counters load the last pixel of the frame: h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - de_o = 0.
  - hsync_o = ~HSYNC_POL; vsync_o = ~VSYNC_POL.
  - x_o = H_TOTAL-1; y_o = V_TOTAL-1.
  - line_start_o = 0; frame_start_o = 0.
- State: h_cnt (XW bits) and v_cnt (YW bits). x_o and y_o are direct copies of h_cnt and v_cnt.
- Counters change only on a rising clk_i edge with pix_strb_i = 1:
  - h_cnt = H_TOTAL-1 wraps to 0, else h_cnt+1.
  - v_cnt advances only when h_cnt wraps: v_cnt = V_TOTAL-1 wraps to 0, else v_cnt+1.
- Registered decode outputs load on the same edge from the NEXT counter values, so all outputs are coherent with x_o/y_o with zero extra latency:
  - de_o = (h_next < H_ACTIVE) && (v_next < V_ACTIVE)
  - hsync_o = HSYNC_POL when H_ACTIVE+H_FP ≤ h_next < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL
  - vsync_o = VSYNC_POL when V_ACTIVE+V_FP ≤ v_next < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL. vsync changes at the line boundary, together with h = 0.
- Between strobes (pix_strb_i = 0), every output except the pulses holds its value.
- line_start_o: set on the strobe edge where h_next = 0; cleared on the next clk_i edge regardless of pix_strb_i. frame_start_o follows the same rule when h_next = 0 and v_next = 0.
- If pix_strb_i is high on consecutive clk_i cycles (divisor 1), the pulses follow the same rule: high only on the cycle after a qualifying strobe.
- Arithmetic: all comparisons are unsigned at counter width. Boundary constants are truncated to XW/YW and must fit; no other overflow is possible.
- The first strobe after reset lands on (0,0): de_o = 1, line_start_o = 1, frame_start_o = 1 for one clk.
- Reset mid-frame: immediate return to the reset state, with pulses cleared in the same cycle. Counting resumes with the first strobe after release.
- Strobe sampled during reset: ignored.

Test Plan:
- Reset values: assert arst_i mid-cycle → x_o=799, y_o=524, de_o=0, hsync_o=1, vsync_o=1, pulses 0, all asynchronously.
- First strobe after release → x_o=0, y_o=0, de_o=1; frame_start_o and line_start_o high for exactly 1 clk. With strobe every 4 clks, x_o/de_o hold for 4 clks.
- Horizontal timing (strobe every clk): de_o falls when x_o=640. hsync_o low exactly for x_o 656..751 (96 strobes), high at 752.
- Line wrap: x_o 799→0 increments y_o 0→1. line_start_o pulses once; frame_start_o stays 0.
- Frame wrap and vsync: vsync_o low exactly for y_o 490..491, changing on the x_o=0 edge. (799,524)→(0,0) fires frame_start_o; count 525 line_start pulses per frame.
- Reset mid-frame at (300,200) with strobes active → outputs return to reset values. The first post-reset strobe yields (0,0) and frame_start_o; the strobe sampled during reset causes no advance.
